// File: rtl/trace_pkg.sv
// Shared encodings for the trace monitor: run states, halt causes and trace entry sizing.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_LIMIT = 2'd1,
    CAUSE_WATCH = 2'd2,
    CAUSE_LOOP  = 2'd3
  } cause_t;

  localparam int ENTRY_W_DEF = 16 + 19 + 19;

  // Trace entry is packed as {cycle, pc, instr}.
  function automatic int entry_w(input int cyc_w, input int pc_w, input int data_w);
    return cyc_w + pc_w + data_w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular trace buffer with overwrite-oldest or drop-newest behaviour when full,
// registered pop output and a sticky overflow flag.
module trace_fifo #(
  parameter int W     = 54,
  parameter int DEPTH = 16,
  parameter int WRAP  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic                       rd_valid,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic          full, do_pop, push_ok, push_ovw, lost, wr;

  always_comb begin
    full     = (count == FULL_CNT);
    do_pop   = pop && (count != '0);
    push_ok  = push && (!full || do_pop);
    lost     = push && full && !do_pop;
    push_ovw = lost && (WRAP != 0);
    wr       = push_ok || push_ovw;
  end

  // Storage carries no reset; contents are only meaningful below count.
  always_ff @(posedge clk) begin
    if (wr && !clr) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      dout     <= '0;
    end else if (clr) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_pop;
      if (do_pop) dout <= mem[rptr];
      if (wr) wptr <= wptr + 1'b1;
      if (do_pop || push_ovw) rptr <= rptr + 1'b1;
      if (push_ok && !do_pop) count <= count + 1'b1;
      else if (do_pop && !push_ok) count <= count - 1'b1;
      if (lost) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/trace_monitor.sv
// Debug monitor for the 19-bit core: records retired instructions, tracks one watched
// memory word and halts on cycle limit, watchpoint write or a jump-to-self idiom.
//
// state | meaning
// IDLE  | out of reset, waiting for arm
// RUN   | counting cycles, recording retires, checking halt conditions
// HALT  | run stopped; counters and watch value frozen, trace readable
module trace_monitor
  import trace_pkg::*;
#(
  parameter int DATA_W = 19,
  parameter int PC_W   = 19,
  parameter int DEPTH  = 16,
  parameter int CYC_W  = 16,
  parameter int LOOP_N = 4,
  parameter int WRAP   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic [CYC_W-1:0]         cycle_limit,
  input  logic [PC_W-1:0]          watch_addr,
  input  logic                     watch_stop,
  input  logic                     ret_valid,
  input  logic [PC_W-1:0]          ret_pc,
  input  logic [DATA_W-1:0]        ret_instr,
  input  logic                     dmem_we,
  input  logic [PC_W-1:0]          dmem_addr,
  input  logic [DATA_W-1:0]        dmem_wdata,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [PC_W-1:0]          rd_pc,
  output logic [DATA_W-1:0]        rd_instr,
  output logic [CYC_W-1:0]         rd_cycle,
  output logic                     running,
  output logic                     halted,
  output logic [1:0]               halt_cause,
  output logic [DATA_W-1:0]        watch_value,
  output logic [CYC_W-1:0]         cycle_count,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int EW = entry_w(CYC_W, PC_W, DATA_W);
  localparam int LW = $clog2(LOOP_N + 1);

  state_t          state;
  cause_t          cause;
  logic [LW-1:0]   loop_cnt, loop_next;
  logic [PC_W-1:0] last_pc;
  logic            limit_hit, watch_wr, loop_hit, same_pc, arm_clr, push;
  logic [EW-1:0]   dout;

  always_comb begin
    limit_hit = (cycle_limit != '0) &&
                (({1'b0, cycle_count} + 1'b1) == {1'b0, cycle_limit});
    watch_wr  = dmem_we && (dmem_addr == watch_addr);
    // An empty loop counter means no retire seen since arm, so nothing to compare against.
    same_pc   = (loop_cnt != '0) && (ret_pc == last_pc);
    loop_next = same_pc ? loop_cnt + 1'b1 : LW'(1);
    loop_hit  = ret_valid && (loop_next == LW'(LOOP_N));
    arm_clr   = arm && (state != RUN);
    push      = (state == RUN) && ret_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cause       <= CAUSE_NONE;
      cycle_count <= '0;
      watch_value <= '0;
      loop_cnt    <= '0;
      last_pc     <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (arm) begin
            state       <= RUN;
            cause       <= CAUSE_NONE;
            cycle_count <= '0;
            watch_value <= '0;
            loop_cnt    <= '0;
          end
        end
        RUN: begin
          if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
          if (watch_wr) watch_value <= dmem_wdata;
          if (ret_valid) begin
            loop_cnt <= loop_next;
            last_pc  <= ret_pc;
          end
          if (limit_hit) begin
            state <= HALT;
            cause <= CAUSE_LIMIT;
          end else if (watch_wr && watch_stop) begin
            state <= HALT;
            cause <= CAUSE_WATCH;
          end else if (loop_hit) begin
            state <= HALT;
            cause <= CAUSE_LOOP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign running    = (state == RUN);
  assign halted     = (state == HALT);
  assign halt_cause = cause;

  trace_fifo #(.W(EW), .DEPTH(DEPTH), .WRAP(WRAP)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (arm_clr),
    .push     (push),
    .din      ({cycle_count, ret_pc, ret_instr}),
    .pop      (rd_en),
    .rd_valid (rd_valid),
    .dout     (dout),
    .count    (count),
    .overflow (overflow)
  );

  assign {rd_cycle, rd_pc, rd_instr} = dout;

endmodule

// File: tb/tb_trace_monitor.sv
// Directed bench for trace_monitor: one 16-deep instance plus 4-deep wrap and drop instances
// sharing the same stimulus.
module tb_trace_monitor;

  localparam int DW = 19;
  localparam int PW = 19;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, arm, watch_stop, ret_valid, dmem_we, rd_en;
  logic [CW-1:0] cycle_limit;
  logic [PW-1:0] watch_addr, ret_pc, dmem_addr;
  logic [DW-1:0] ret_instr, dmem_wdata;

  logic          a_rd_valid, a_running, a_halted, a_overflow;
  logic [PW-1:0] a_rd_pc;
  logic [DW-1:0] a_rd_instr, a_watch_value;
  logic [CW-1:0] a_rd_cycle, a_cycle_count;
  logic [1:0]    a_halt_cause;
  logic [4:0]    a_count;

  logic          w_rd_valid, w_running, w_halted, w_overflow;
  logic [PW-1:0] w_rd_pc;
  logic [DW-1:0] w_rd_instr, w_watch_value;
  logic [CW-1:0] w_rd_cycle, w_cycle_count;
  logic [1:0]    w_halt_cause;
  logic [2:0]    w_count;

  logic          d_rd_valid, d_running, d_halted, d_overflow;
  logic [PW-1:0] d_rd_pc;
  logic [DW-1:0] d_rd_instr, d_watch_value;
  logic [CW-1:0] d_rd_cycle, d_cycle_count;
  logic [1:0]    d_halt_cause;
  logic [2:0]    d_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trace_monitor #(.DATA_W(DW), .PC_W(PW), .DEPTH(16), .CYC_W(CW), .LOOP_N(4), .WRAP(1)) dut_a (
    .clk(clk), .rst(rst), .arm(arm), .cycle_limit(cycle_limit), .watch_addr(watch_addr),
    .watch_stop(watch_stop), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .rd_en(rd_en),
    .rd_valid(a_rd_valid), .rd_pc(a_rd_pc), .rd_instr(a_rd_instr), .rd_cycle(a_rd_cycle),
    .running(a_running), .halted(a_halted), .halt_cause(a_halt_cause),
    .watch_value(a_watch_value), .cycle_count(a_cycle_count), .count(a_count),
    .overflow(a_overflow));

  trace_monitor #(.DATA_W(DW), .PC_W(PW), .DEPTH(4), .CYC_W(CW), .LOOP_N(4), .WRAP(1)) dut_w (
    .clk(clk), .rst(rst), .arm(arm), .cycle_limit(cycle_limit), .watch_addr(watch_addr),
    .watch_stop(watch_stop), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .rd_en(rd_en),
    .rd_valid(w_rd_valid), .rd_pc(w_rd_pc), .rd_instr(w_rd_instr), .rd_cycle(w_rd_cycle),
    .running(w_running), .halted(w_halted), .halt_cause(w_halt_cause),
    .watch_value(w_watch_value), .cycle_count(w_cycle_count), .count(w_count),
    .overflow(w_overflow));

  trace_monitor #(.DATA_W(DW), .PC_W(PW), .DEPTH(4), .CYC_W(CW), .LOOP_N(4), .WRAP(0)) dut_d (
    .clk(clk), .rst(rst), .arm(arm), .cycle_limit(cycle_limit), .watch_addr(watch_addr),
    .watch_stop(watch_stop), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .rd_en(rd_en),
    .rd_valid(d_rd_valid), .rd_pc(d_rd_pc), .rd_instr(d_rd_instr), .rd_cycle(d_rd_cycle),
    .running(d_running), .halted(d_halted), .halt_cause(d_halt_cause),
    .watch_value(d_watch_value), .cycle_count(d_cycle_count), .count(d_count),
    .overflow(d_overflow));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input int pc);
    ret_valid = 1'b1;
    ret_pc    = PW'(pc);
    ret_instr = DW'(pc + 100);
    tick();
    ret_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  int cc_prev;

  initial begin
    rst = 1'b1; arm = 1'b0; cycle_limit = '0; watch_addr = '0; watch_stop = 1'b0;
    ret_valid = 1'b0; ret_pc = '0; ret_instr = '0; dmem_we = 1'b0; dmem_addr = '0;
    dmem_wdata = '0; rd_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_running", a_running, 0);
    chk("rst_halted", a_halted, 0);
    chk("rst_cause", a_halt_cause, 0);
    chk("rst_count", a_count, 0);
    chk("rst_cycles", a_cycle_count, 0);
    chk("rst_overflow", a_overflow, 0);
    chk("rst_rd_valid", a_rd_valid, 0);

    // Cycle limit of 10 with one retire per cycle.
    cycle_limit = 16'd10;
    do_arm();
    chk("lim_running", a_running, 1);
    for (int i = 0; i < 10; i++) retire(i);
    chk("lim_halted", a_halted, 1);
    chk("lim_cause", a_halt_cause, 1);
    chk("lim_count", a_count, 10);
    chk("lim_cycles", a_cycle_count, 10);
    retire(50);
    chk("lim_frozen_cycles", a_cycle_count, 10);
    chk("lim_no_push", a_count, 10);
    for (int i = 0; i < 10; i++) begin
      rd_en = 1'b1;
      tick();
      chk("lim_rd_valid", a_rd_valid, 1);
      chk("lim_rd_pc", a_rd_pc, i);
      chk("lim_rd_cycle", a_rd_cycle, i);
      chk("lim_rd_instr", a_rd_instr, i + 100);
    end
    rd_en = 1'b0;
    tick();
    chk("lim_rd_idle", a_rd_valid, 0);
    chk("lim_rd_hold", a_rd_pc, 9);
    chk("lim_empty", a_count, 0);

    // Watchpoint: stray write elsewhere, then hit at cycle 5.
    cycle_limit = '0; watch_addr = 19'd102; watch_stop = 1'b1;
    do_arm();
    chk("wat_cause_clr", a_halt_cause, 0);
    dmem_we = 1'b1; dmem_addr = 19'd101; dmem_wdata = 19'd3;
    tick();
    dmem_we = 1'b0;
    chk("wat_other_addr", a_watch_value, 0);
    chk("wat_still_run", a_running, 1);
    tick(); tick(); tick(); tick();
    chk("wat_cycle5", a_cycle_count, 5);
    dmem_we = 1'b1; dmem_addr = 19'd102; dmem_wdata = 19'd7;
    tick();
    dmem_we = 1'b0;
    chk("wat_value", a_watch_value, 7);
    chk("wat_cause", a_halt_cause, 2);
    chk("wat_running", a_running, 0);
    chk("wat_cycles", a_cycle_count, 6);

    // Self-loop idiom.
    watch_stop = 1'b0;
    do_arm();
    chk("loop_watch_clr", a_watch_value, 0);
    retire(3); retire(4); retire(5); retire(5); retire(5);
    chk("loop_not_yet", a_running, 1);
    retire(5);
    chk("loop_halted", a_halted, 1);
    chk("loop_cause", a_halt_cause, 3);
    chk("loop_count", a_count, 6);

    // Limit and watch in the same cycle: limit wins, write still captured.
    cycle_limit = 16'd3; watch_stop = 1'b1;
    do_arm();
    tick(); tick();
    dmem_we = 1'b1; dmem_addr = 19'd102; dmem_wdata = 19'd9;
    tick();
    dmem_we = 1'b0;
    chk("prio_cause", a_halt_cause, 1);
    chk("prio_value", a_watch_value, 9);

    // Overfill the 4-deep instances.
    cycle_limit = '0; watch_stop = 1'b0;
    do_arm();
    chk("ovf_count_clr", w_count, 0);
    for (int i = 0; i < 6; i++) retire(i);
    chk("wrap_count", w_count, 4);
    chk("wrap_overflow", w_overflow, 1);
    chk("drop_count", d_count, 4);
    chk("drop_overflow", d_overflow, 1);
    for (int i = 0; i < 4; i++) begin
      rd_en = 1'b1;
      tick();
      chk("wrap_rd_pc", w_rd_pc, i + 2);
      chk("drop_rd_pc", d_rd_pc, i);
    end
    rd_en = 1'b0;

    // Arm while running is ignored.
    cc_prev = int'(a_cycle_count);
    do_arm();
    chk("arm_in_run", a_cycle_count, cc_prev + 1);

    rst = 1'b1; tick(); rst = 1'b0;
    do_arm();
    for (int i = 10; i < 14; i++) retire(i);
    chk("full_count", w_count, 4);
    chk("full_no_ovf", w_overflow, 0);
    ret_valid = 1'b1; ret_pc = 19'd14; ret_instr = 19'd114; rd_en = 1'b1;
    tick();
    ret_valid = 1'b0; rd_en = 1'b0;
    chk("pp_rd_valid", w_rd_valid, 1);
    chk("pp_rd_pc", w_rd_pc, 10);
    chk("pp_count", w_count, 4);
    chk("pp_overflow", w_overflow, 0);
    chk("pp_drop_count", d_count, 4);
    chk("pp_drop_ovf", d_overflow, 0);
    chk("pp_drop_pc", d_rd_pc, 10);

    // Reset in the middle of a run, then pop while empty.
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_running", w_running, 0);
    chk("mid_rst_count", w_count, 0);
    chk("mid_rst_cause", w_halt_cause, 0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("empty_pop", w_rd_valid, 0);
    chk("empty_pop_count", w_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
